// File: rtl/uart_rx_core_if.sv
// Receiver-side bundle: serial line and baud divisor in, tick/byte/status out.
// The master end drives the line, the slave end is the receiver core.
interface uart_rx_core_if #(
  parameter int DBIT       = 8,
  parameter int TIMER_BITS = 11
);
  logic                  rx;
  logic [TIMER_BITS-1:0] final_value;
  logic                  s_tick;
  logic                  rx_done_tick;
  logic [DBIT-1:0]       rx_dout;
  logic                  frame_err;

  modport master (
    output rx, final_value,
    input  s_tick, rx_done_tick, rx_dout, frame_err
  );

  modport slave (
    input  rx, final_value,
    output s_tick, rx_done_tick, rx_dout, frame_err
  );
endinterface

// File: rtl/uart_rx_core.sv
// 16x-oversampling UART receiver with built-in baud tick; done pulse ~8+16*DBIT+SB_TICK ticks
// after start detection plus 2 sync clocks. No backpressure: rx_dout holds until overwritten.
module uart_rx_core #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int TIMER_BITS = 11
) (
  input logic            clk,
  input logic            reset_n,
  uart_rx_core_if.slave  bus
);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  // Tick counter is widened only when a 1.5/2 stop-bit length needs more than 16 ticks.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [TIMER_BITS-1:0] cnt_q, cnt_d;
  logic                  tick_q;
  logic [1:0]            sync_q;
  logic                  rx_s;
  state_t                state_q;
  logic [SW-1:0]         s_q;
  logic [NW-1:0]         n_q;
  logic [DBIT-1:0]       shift_q;
  logic [DBIT-1:0]       dout_q;
  logic                  done_q;
  logic                  ferr_q;

  always_comb begin
    cnt_d = (cnt_q == bus.final_value) ? '0 : cnt_q + 1'b1;
  end

  // tick_q is registered from the next count so it is high while cnt_q equals final_value.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == bus.final_value);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.rx};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          if (tick_q) begin
            if (s_q == SW'(7)) begin
              if (!rx_s) begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick_q) begin
            if (s_q == SW'(15)) begin
              s_q     <= '0;
              shift_q <= {rx_s, shift_q[DBIT-1:1]};
              if (n_q == NW'(DBIT - 1)) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick_q) begin
            if (s_q == SW'(SB_TICK - 1)) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              dout_q  <= shift_q;
              ferr_q  <= ~rx_s;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_tick       = tick_q;
  assign bus.rx_done_tick = done_q;
  assign bus.rx_dout      = dout_q;
  assign bus.frame_err    = ferr_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: baud tick, clean/back-to-back/glitch/framing-error/abort frames.
// A small divisor keeps each frame near 640 clocks.
module tb_uart_rx_core;
  localparam int DBIT   = 8;
  localparam int SBT    = 16;
  localparam int TBITS  = 11;
  localparam int FV     = 3;
  localparam int TCLK   = FV + 1;
  localparam int BITCLK = 16 * TCLK;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   done_cnt = 0;
  int   lat = 0;
  int   base;
  int   ones;
  logic [3:0] pat;

  always #5 clk = ~clk;

  uart_rx_core_if #(.DBIT(DBIT), .TIMER_BITS(TBITS)) bus ();

  uart_rx_core #(.DBIT(DBIT), .SB_TICK(SBT), .TIMER_BITS(TBITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.rx_done_tick) begin
      done_cnt++;
      lat = cyc - start_cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; every bit is held for 16 ticks, the stop level for stop_clks.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_clks);
    bus.rx = 1'b0;
    start_cyc = cyc;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (BITCLK) @(negedge clk);
    end
    bus.rx = stop_lvl;
    repeat (stop_clks) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  initial begin
    bus.rx = 1'b1;
    bus.final_value = '0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_s_tick", bus.s_tick, 0);
    check_eq("rst_done", bus.rx_done_tick, 0);
    check_eq("rst_dout", bus.rx_dout, 0);
    check_eq("rst_ferr", bus.frame_err, 0);

    reset_n = 1'b0;
    ones = 0;
    repeat (8) begin
      @(negedge clk);
      ones += bus.s_tick;
    end
    check_eq("fv0_tick_every_cycle", ones, 8);

    bus.final_value = TBITS'(FV);
    repeat (6) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("midcount_rst_s_tick", bus.s_tick, 0);
    reset_n = 1'b0;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[i] = bus.s_tick;
    end
    check_eq("fv3_phase_after_rst", pat, 4'b0100);
    ones = 0;
    repeat (40) begin
      @(negedge clk);
      ones += bus.s_tick;
    end
    check_eq("fv3_tick_rate", ones, 10);
    repeat (20) @(negedge clk);

    base = done_cnt;
    send_frame(8'hA5, 1'b1, BITCLK);
    check_eq("a5_done_cnt", done_cnt - base, 1);
    check_eq("a5_dout", bus.rx_dout, 8'hA5);
    check_eq("a5_ferr", bus.frame_err, 0);
    check_eq("a5_latency_604_616", (lat >= 604 && lat <= 616), 1);
    repeat (8 * TCLK) @(negedge clk);

    base = done_cnt;
    send_frame(8'h00, 1'b1, BITCLK);
    check_eq("b2b_00_dout", bus.rx_dout, 8'h00);
    check_eq("b2b_00_ferr", bus.frame_err, 0);
    send_frame(8'hFF, 1'b1, BITCLK);
    check_eq("b2b_ff_dout", bus.rx_dout, 8'hFF);
    check_eq("b2b_ff_ferr", bus.frame_err, 0);
    check_eq("b2b_done_cnt", done_cnt - base, 2);
    repeat (8 * TCLK) @(negedge clk);

    base = done_cnt;
    bus.rx = 1'b0;
    repeat (3 * TCLK) @(negedge clk);
    bus.rx = 1'b1;
    repeat (40 * TCLK) @(negedge clk);
    check_eq("glitch_no_done", done_cnt - base, 0);
    check_eq("glitch_dout_kept", bus.rx_dout, 8'hFF);

    // Stop bit released after 10 ticks so the START re-entered from the low line is rejected.
    base = done_cnt;
    send_frame(8'h3C, 1'b0, 10 * TCLK);
    repeat (40 * TCLK) @(negedge clk);
    check_eq("ferr_done_cnt", done_cnt - base, 1);
    check_eq("ferr_dout", bus.rx_dout, 8'h3C);
    check_eq("ferr_flag", bus.frame_err, 1);

    base = done_cnt;
    bus.rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = pat[0] ^ pat[0] ^ ((8'h5A >> i) & 8'h01) ? 1'b1 : 1'b0;
      repeat (BITCLK) @(negedge clk);
    end
    reset_n = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    check_eq("abort_rst_dout", bus.rx_dout, 0);
    check_eq("abort_rst_ferr", bus.frame_err, 0);
    repeat (20 * TCLK) @(negedge clk);
    check_eq("abort_no_done", done_cnt - base, 0);
    send_frame(8'h96, 1'b1, BITCLK);
    repeat (8 * TCLK) @(negedge clk);
    check_eq("after_abort_done_cnt", done_cnt - base, 1);
    check_eq("after_abort_dout", bus.rx_dout, 8'h96);
    check_eq("after_abort_ferr", bus.frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
